// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter
// Shares one single-port memory bus between the Kronos instruction-fetch
// port and its load/store port. The winning request is latched onto the
// memory bus and held until mem_ack. Data normally wins a tie. A streak
// counter forces a pending fetch through after MAX_DATA_STREAK data grants.
// Acks and read data are routed back combinationally in the mem_ack cycle.

module kronos_mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rstz,

    // instruction-fetch port
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_data,

    // load/store port
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,

    // unified memory bus
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    // Streak limit as a 4-bit value; the parameter range is 1..15.
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t      state_r;
    logic [3:0]  streak_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wr_data_r;
    logic [3:0]  mem_mask_r;
    logic        mem_wr_en_r;

    logic        rearb_s;
    logic        cand_i_s;
    logic        cand_d_s;
    logic        win_i_s;
    logic        win_d_s;
    logic [3:0]  streak_next_s;

    // Which requesters may compete this cycle: everyone while idle, only the
    // non-acked side in the completion cycle of a grant, nobody otherwise.
    always_comb begin
        rearb_s  = 1'b0;
        cand_i_s = 1'b0;
        cand_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                rearb_s  = 1'b1;
                cand_i_s = instr_req;
                cand_d_s = data_req;
            end
            GNT_I: begin
                rearb_s  = mem_ack;
                cand_i_s = 1'b0;
                cand_d_s = data_req & mem_ack;
            end
            GNT_D: begin
                rearb_s  = mem_ack;
                cand_i_s = instr_req & mem_ack;
                cand_d_s = 1'b0;
            end
            default: begin
                // An unreachable encoding behaves like IDLE so the bus recovers.
                rearb_s  = 1'b1;
                cand_i_s = instr_req;
                cand_d_s = data_req;
            end
        endcase
    end

    // Fixed data-first priority, overridden once the data streak hits its limit.
    always_comb begin
        win_i_s = 1'b0;
        win_d_s = 1'b0;
        if (cand_d_s && !(cand_i_s && (streak_r >= STREAK_MAX))) begin
            win_d_s = 1'b1;
        end else if (cand_i_s) begin
            win_i_s = 1'b1;
        end else begin
            win_i_s = 1'b0;
            win_d_s = 1'b0;
        end
    end

    // Streak counts data grants that overtook a waiting fetch; any fetch grant
    // or any data grant without a waiting fetch starts it over.
    always_comb begin
        streak_next_s = streak_r;
        if (win_i_s) begin
            streak_next_s = 4'd0;
        end else if (win_d_s) begin
            if (instr_req) begin
                streak_next_s = (streak_r >= STREAK_MAX) ? STREAK_MAX : (streak_r + 4'd1);
            end else begin
                streak_next_s = 4'd0;
            end
        end else begin
            streak_next_s = streak_r;
        end
    end

    // Grant FSM: latches the winner's bus fields and holds them for the whole grant.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_r       <= IDLE;
            streak_r      <= 4'd0;
            mem_addr_r    <= 32'd0;
            mem_wr_data_r <= 32'd0;
            mem_mask_r    <= 4'd0;
            mem_wr_en_r   <= 1'b0;
        end else begin
            streak_r <= streak_next_s;
            if (win_d_s) begin
                state_r       <= GNT_D;
                mem_addr_r    <= data_addr;
                mem_wr_data_r <= data_wr_data;
                mem_mask_r    <= data_mask;
                mem_wr_en_r   <= data_wr_en;
            end else if (win_i_s) begin
                state_r       <= GNT_I;
                mem_addr_r    <= instr_addr;
                mem_wr_data_r <= 32'd0;
                mem_mask_r    <= 4'hF;
                mem_wr_en_r   <= 1'b0;
            end else if (rearb_s) begin
                state_r <= IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Bus request is a direct decode of the grant state, so reset drops it at once.
    assign mem_req     = (state_r == GNT_I) || (state_r == GNT_D);
    assign mem_addr    = mem_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign mem_mask    = mem_mask_r;
    assign mem_wr_en   = mem_wr_en_r;

    // Completion is routed to the owner only; read data is a plain pass-through.
    assign instr_ack    = (state_r == GNT_I) && mem_ack;
    assign data_ack     = (state_r == GNT_D) && mem_ack;
    assign instr_data   = mem_rd_data;
    assign data_rd_data = mem_rd_data;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Self-checking bench for kronos_mem_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.

module tb_kronos_mem_arbiter;

    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        instr_ack;
    logic [31:0] instr_data;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, what was captured, and the streak.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_streak;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;
    logic        m_wen;

    kronos_mem_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack), .instr_data(instr_data),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask), .data_wr_en(data_wr_en),
        .data_req(data_req), .data_ack(data_ack), .data_rd_data(data_rd_data),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask), .mem_wr_en(mem_wr_en),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    task automatic inputs_idle();
        instr_addr = 32'd0; instr_req = 1'b0;
        data_addr = 32'd0; data_wr_data = 32'd0; data_mask = 4'd0; data_wr_en = 1'b0; data_req = 1'b0;
        mem_ack = 1'b0; mem_rd_data = 32'd0;
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic model_step();
        bit done, ci, cd;
        done = (m_owner != 0) && mem_ack;
        if (m_owner == 0 || done) begin
            ci = instr_req && !(done && m_owner == 1);
            cd = data_req  && !(done && m_owner == 2);
            if (cd && !(ci && m_streak >= MAX_STREAK)) begin
                m_owner = 2;
                m_addr = data_addr; m_wdata = data_wr_data; m_mask = data_mask; m_wen = data_wr_en;
                m_streak = instr_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK) : 0;
            end else if (ci) begin
                m_owner = 1;
                m_addr = instr_addr; m_wdata = 32'd0; m_mask = 4'hF; m_wen = 1'b0;
                m_streak = 0;
            end else begin
                m_owner = 0;
            end
        end
    endtask

    task automatic test_reset();
        // rstz is low on entry
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
        n_tests++; if (instr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_instr_ack: got %0b want 0", instr_ack); end
        n_tests++; if (data_ack !== 1'b0) begin n_fail++; $display("FAIL reset_data_ack: got %0b want 0", data_ack); end
        n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if (mem_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wr_data: got %h want 0", mem_wr_data); end
        n_tests++; if (mem_mask !== 4'd0) begin n_fail++; $display("FAIL reset_mem_mask: got %h want 0", mem_mask); end
        n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr_en: got %0b want 0", mem_wr_en); end
        rstz = 1'b1;
        data_req = 1'b1; data_addr = 32'h44; data_wr_data = 32'h1234; data_mask = 4'hF;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL reset_pre_grant: req %0b addr %h want 1 00000044", mem_req, mem_addr); end
        mem_ack = 1'b1; rstz = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_abort_req: got %0b want 0", mem_req); end
        n_tests++; if (instr_ack !== 1'b0 || data_ack !== 1'b0) begin n_fail++; $display("FAIL reset_abort_ack: got i%0b d%0b want 0 0", instr_ack, data_ack); end
        data_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1; rstz = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_no_grant: got %0b want 0", mem_req); end
        end
        @(posedge clk); #1;
        instr_req = 1'b1; instr_addr = 32'h200;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL reset_new_grant: req %0b addr %h want 1 00000200", mem_req, mem_addr); end
        mem_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (instr_ack !== 1'b1) begin n_fail++; $display("FAIL reset_new_ack: got %0b want 1", instr_ack); end
        @(posedge clk); #1; instr_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_back_idle: got %0b want 0", mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        instr_req = 1'b1; instr_addr = 32'h100;
        @(posedge clk); #1;
        n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
        n_tests++; if (mem_wr_en !== 1'b0 || mem_mask !== 4'hF) begin n_fail++; $display("FAIL fetch_ctrl: wr_en %0b mask %h want 0 f", mem_wr_en, mem_mask); end
        mem_ack = 1'b1; mem_rd_data = 32'h00000013;
        @(negedge clk);
        n_tests++; if (instr_ack !== 1'b1 || instr_data !== 32'h13) begin n_fail++; $display("FAIL fetch_ack: ack %0b data %h want 1 00000013", instr_ack, instr_data); end
        n_tests++; if (data_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_other_ack: got %0b want 0", data_ack); end
        @(posedge clk); #1; instr_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (instr_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_one_cycle: ack %0b req %0b want 0 0", instr_ack, mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        instr_req = 1'b1; instr_addr = 32'h300;
        data_req = 1'b1; data_addr = 32'h10; data_wr_en = 1'b0; data_mask = 4'hF;
        @(posedge clk); #1;
        n_tests++; if (mem_addr !== 32'h10 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL simul_data_first: addr %h wr_en %0b want 00000010 0", mem_addr, mem_wr_en); end
        mem_ack = 1'b1; mem_rd_data = 32'hFFFFFFFF;
        @(negedge clk);
        n_tests++; if (data_ack !== 1'b1 || data_rd_data !== 32'hFFFFFFFF || instr_ack !== 1'b0) begin
            n_fail++; $display("FAIL simul_data_ack: dack %0b rd %h iack %0b want 1 ffffffff 0", data_ack, data_rd_data, instr_ack); end
        @(posedge clk); #1; data_req = 1'b0; mem_ack = 1'b0;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL simul_no_bubble: req %0b addr %h want 1 00000300", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rd_data = 32'h55;
        @(negedge clk);
        n_tests++; if (instr_ack !== 1'b1 || instr_data !== 32'h55 || data_ack !== 1'b0) begin
            n_fail++; $display("FAIL simul_instr_ack: iack %0b data %h dack %0b want 1 00000055 0", instr_ack, instr_data, data_ack); end
        @(posedge clk); #1; instr_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL simul_idle: got %0b want 0", mem_req); end
        @(posedge clk); #1;
    endtask

    // Both sides keep requesting: the acked side is excluded in its ack cycle,
    // so grants alternate data/fetch with no idle cycle in between.
    task automatic test_back_to_back();
        int st, ft;
        bit exp_d;
        st = 0; ft = 0;
        data_req = 1'b1; data_wr_en = 1'b1; data_mask = 4'hF; data_addr = 32'h1000; data_wr_data = 32'hA0;
        instr_req = 1'b1; instr_addr = 32'h2000;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            mem_ack = 1'b1; mem_rd_data = $urandom;
            exp_d = (k % 2 == 0);
            @(negedge clk);
            n_tests++; if (data_ack !== exp_d || instr_ack !== !exp_d) begin
                n_fail++; $display("FAIL b2b_owner k=%0d: dack %0b iack %0b want %0b %0b", k, data_ack, instr_ack, exp_d, !exp_d); end
            n_tests++; if (mem_addr !== (exp_d ? 32'h1000 + 32'(4 * st) : 32'h2000 + 32'(4 * ft)) || mem_wr_en !== exp_d) begin
                n_fail++; $display("FAIL b2b_fields k=%0d: addr %h wr_en %0b", k, mem_addr, mem_wr_en); end
            @(posedge clk); #1;
            if (exp_d) begin
                st++;
                data_addr = 32'h1000 + 32'(4 * st); data_wr_data = 32'hA0 + 32'(st);
                if (st == 10) data_req = 1'b0;
            end else begin
                ft++;
                instr_addr = 32'h2000 + 32'(4 * ft);
                if (k == 19) instr_req = 1'b0;
            end
        end
        mem_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0b want 0", mem_req); end
        @(posedge clk); #1;
    endtask

    // Fetch withdrawn in each data-ack cycle so data keeps winning from IDLE;
    // after MAX_STREAK such grants the fetch must be forced through.
    task automatic test_starvation();
        data_wr_en = 1'b0; data_mask = 4'hF;
        for (int i = 0; i < MAX_STREAK; i++) begin
            instr_req = 1'b1; instr_addr = 32'h3000;
            data_req = 1'b1; data_addr = 32'h4000 + 32'(4 * i);
            @(posedge clk); #1;
            n_tests++; if (mem_addr !== 32'h4000 + 32'(4 * i)) begin n_fail++; $display("FAIL starve_data_grant i=%0d: got %h", i, mem_addr); end
            mem_ack = 1'b1; instr_req = 1'b0;
            @(negedge clk);
            n_tests++; if (data_ack !== 1'b1) begin n_fail++; $display("FAIL starve_data_ack i=%0d: got %0b want 1", i, data_ack); end
            @(posedge clk); #1; mem_ack = 1'b0;
        end
        instr_req = 1'b1; instr_addr = 32'h3000;
        data_req = 1'b1; data_addr = 32'h4100;
        @(posedge clk); #1;
        n_tests++; if (mem_addr !== 32'h3000 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL starve_forced: addr %h wr_en %0b want 00003000 0", mem_addr, mem_wr_en); end
        mem_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (instr_ack !== 1'b1 || data_ack !== 1'b0) begin n_fail++; $display("FAIL starve_fetch_ack: iack %0b dack %0b want 1 0", instr_ack, data_ack); end
        @(posedge clk); #1; instr_req = 1'b0;
        n_tests++; if (mem_addr !== 32'h4100) begin n_fail++; $display("FAIL starve_data_resume: got %h want 00004100", mem_addr); end
        @(negedge clk);
        n_tests++; if (data_ack !== 1'b1) begin n_fail++; $display("FAIL starve_data_resume_ack: got %0b want 1", data_ack); end
        @(posedge clk); #1; data_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_fields();
        data_req = 1'b1; data_wr_en = 1'b1; data_mask = 4'b0011; data_wr_data = 32'hB02F8293; data_addr = 32'h80;
        @(posedge clk); #1;
        data_wr_en = 1'b0; data_mask = 4'hC; data_wr_data = 32'h0; data_addr = 32'h999;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            @(negedge clk);
            n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_wr_data !== 32'hB02F8293 || mem_mask !== 4'b0011 || mem_wr_en !== 1'b1) begin
                n_fail++; $display("FAIL store_hold c=%0d: req %0b addr %h wd %h mask %h we %0b", c, mem_req, mem_addr, mem_wr_data, mem_mask, mem_wr_en); end
            n_tests++; if (data_ack !== (c == 3) || instr_ack !== 1'b0) begin
                n_fail++; $display("FAIL store_ack c=%0d: dack %0b iack %0b want %0b 0", c, data_ack, instr_ack, (c == 3)); end
            @(posedge clk); #1;
        end
        data_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (data_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store_done: dack %0b req %0b want 0 0", data_ack, mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if (instr_ack !== 1'b0 || data_ack !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL spurious c=%0d: iack %0b dack %0b req %0b want 0 0 0", c, instr_ack, data_ack, mem_req); end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; instr_req = 1'b1; instr_addr = 32'h500;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL spurious_after: req %0b addr %h want 1 00000500", mem_req, mem_addr); end
        mem_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (instr_ack !== 1'b1) begin n_fail++; $display("FAIL spurious_after_ack: got %0b want 1", instr_ack); end
        @(posedge clk); #1; instr_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit i_acked, d_acked, exp_ia, exp_da;
        rstz = 1'b0; inputs_idle();
        m_owner = 0; m_streak = 0; m_addr = 32'd0; m_wdata = 32'd0; m_mask = 4'd0; m_wen = 1'b0;
        i_acked = 1'b0; d_acked = 1'b0;
        #1; rstz = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            // fetch requester: occasionally withdraws, which lets data build a streak
            if (!instr_req) begin
                if ($urandom_range(0, 2) == 0) begin instr_req = 1'b1; instr_addr = $urandom; end
            end else if (i_acked) begin
                if ($urandom_range(0, 1) == 0) instr_addr = $urandom; else instr_req = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                instr_req = 1'b0;
            end
            // load/store requester: busy, fields re-randomised after each ack
            if (!data_req || d_acked) begin
                data_req = ($urandom_range(0, 3) != 0);
                data_addr = $urandom; data_mask = 4'($urandom); data_wr_en = 1'($urandom);
            end
            data_wr_data = $urandom;
            mem_ack = (m_owner != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            mem_rd_data = $urandom;
            exp_ia = (m_owner == 1) && mem_ack;
            exp_da = (m_owner == 2) && mem_ack;
            @(negedge clk);
            n_tests++; if (mem_req !== (m_owner != 0)) begin n_fail++; $display("FAIL rand_mem_req cyc=%0d: got %0b want %0b", cyc, mem_req, (m_owner != 0)); end
            n_tests++; if (mem_addr !== m_addr || mem_wr_data !== m_wdata || mem_mask !== m_mask || mem_wr_en !== m_wen) begin
                n_fail++; $display("FAIL rand_bus cyc=%0d: got %h %h %h %0b want %h %h %h %0b", cyc, mem_addr, mem_wr_data, mem_mask, mem_wr_en, m_addr, m_wdata, m_mask, m_wen); end
            n_tests++; if (instr_ack !== exp_ia || data_ack !== exp_da) begin
                n_fail++; $display("FAIL rand_acks cyc=%0d: got i%0b d%0b want i%0b d%0b", cyc, instr_ack, data_ack, exp_ia, exp_da); end
            n_tests++; if (instr_data !== mem_rd_data || data_rd_data !== mem_rd_data) begin
                n_fail++; $display("FAIL rand_rd_data cyc=%0d: got %h %h want %h", cyc, instr_data, data_rd_data, mem_rd_data); end
            i_acked = exp_ia; d_acked = exp_da;
            @(posedge clk);
            model_step();
            #1;
        end
        inputs_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        rstz = 1'b0;
        inputs_idle();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_back_to_back();
        test_starvation();
        test_store_fields();
        test_spurious_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
